// File: rtl/des_pkg.sv
// Shared DES constants and helpers: permutation tables, key shift schedules,
// S-boxes and the round f-function (DES bit 1 is the MSB of every vector).
package des_pkg;

   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

   localparam int FP_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

   localparam int E_T [48] = '{
      32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
      12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
      22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

   localparam int P_T [32] = '{
      16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
      2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
      10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
      14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

   localparam int PC2_T [48] = '{
      14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
      23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   localparam int ENC_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
   localparam int DEC_SHIFT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   localparam int SBOX [8][64] = '{
      '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
      '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
      '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
      '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
      '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
      '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
      '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
      '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

   function automatic logic [63:0] ip_perm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
      return y;
   endfunction

   function automatic logic [63:0] fp_perm(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
      return y;
   endfunction

   function automatic logic [47:0] e_perm(input logic [31:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
      return y;
   endfunction

   function automatic logic [31:0] p_perm(input logic [31:0] x);
      logic [31:0] y;
      y = '0;
      for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
      return y;
   endfunction

   // Parity bits (DES 8,16,..,64) never appear in the table.
   function automatic logic [55:0] pc1_perm(input logic [63:0] x);
      logic [55:0] y;
      y = '0;
      for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
      return y;
   endfunction

   function automatic logic [47:0] pc2_perm(input logic [55:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
      return y;
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
      return (x << n) | (x >> (28 - n));
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
      return (x >> n) | (x << (28 - n));
   endfunction

   // Row is outer bits b1,b6; column is inner bits b2..b5.
   function automatic logic [3:0] sbox_lookup(input int n, input logic [5:0] b);
      return 4'(SBOX[3'(n)][{b[5], b[0], b[4:1]}]);
   endfunction

   function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [31:0] s;
      x = e_perm(r) ^ k;
      s = '0;
      for (int i = 0; i < 8; i++)
         s[5'(31 - 4 * i) -: 4] = sbox_lookup(i, x[6'(47 - 6 * i) -: 6]);
      return p_perm(s);
   endfunction

endpackage

// File: rtl/des_round.sv
// One DES pipeline stage: key-half rotation, subkey, Feistel round,
// and the register set holding the result of round ROUND.
module des_round
   import des_pkg::*;
#(
   parameter int ROUND = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] i_l,
   input  logic [31:0] i_r,
   input  logic [27:0] i_c,
   input  logic [27:0] i_d,
   input  logic        i_mode,
   input  logic        i_valid,
   output logic [31:0] o_l,
   output logic [31:0] o_r,
   output logic [27:0] o_c,
   output logic [27:0] o_d,
   output logic        o_mode,
   output logic        o_valid
);

   localparam int SHL = ENC_SHIFT[ROUND-1];
   localparam int SHR = DEC_SHIFT[ROUND-1];

   logic [27:0] w_c;
   logic [27:0] w_d;
   logic [47:0] w_k;
   logic [31:0] w_f;

   logic [31:0] r_l;
   logic [31:0] r_r;
   logic [27:0] r_c;
   logic [27:0] r_d;
   logic        r_mode;
   logic        r_valid;

   // Rotate key halves (left for encrypt, right for decrypt), then run the round.
   always_comb begin
      w_c = i_mode ? rotr28(i_c, SHR) : rotl28(i_c, SHL);
      w_d = i_mode ? rotr28(i_d, SHR) : rotl28(i_d, SHL);
      w_k = pc2_perm({w_c, w_d});
      w_f = des_f(i_r, w_k);
   end

   // Stage register; data loads every cycle, only valid is meaningful.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_l     <= '0;
         r_r     <= '0;
         r_c     <= '0;
         r_d     <= '0;
         r_mode  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_l     <= i_r;
         r_r     <= i_l ^ w_f;
         r_c     <= w_c;
         r_d     <= w_d;
         r_mode  <= i_mode;
         r_valid <= i_valid;
      end
   end

   assign o_l     = r_l;
   assign o_r     = r_r;
   assign o_c     = r_c;
   assign o_d     = r_d;
   assign o_mode  = r_mode;
   assign o_valid = r_valid;

endmodule

// File: rtl/des_top.sv
// Fully pipelined single-DES engine, one round per stage, one block per clock.
// Define DES_OUTPUT_GATE_EN to force cipher_text to zero when valid_out is low.
module des_top
   import des_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic [63:0] cipher_key,
   input  logic [63:0] plain_text,
   input  logic        encrypt_decrypt,
   input  logic        valid_in,
   output logic [63:0] cipher_text,
   output logic        valid_out
);

   logic [63:0] w_ip;
   logic [55:0] w_cd;
   logic [63:0] w_fp;

   logic [31:0] w_l [17];
   logic [31:0] w_r [17];
   logic [27:0] w_c [17];
   logic [27:0] w_d [17];
   logic        w_m [17];
   logic        w_v [17];

   assign w_ip = ip_perm(plain_text);
   assign w_cd = pc1_perm(cipher_key);

   assign w_l[0] = w_ip[63:32];
   assign w_r[0] = w_ip[31:0];
   assign w_c[0] = w_cd[55:28];
   assign w_d[0] = w_cd[27:0];
   assign w_m[0] = encrypt_decrypt;
   assign w_v[0] = valid_in;

   for (genvar g = 1; g <= 16; g++) begin : g_round
      des_round #(
         .ROUND(g)
      ) u_round (
         .clk    (clk),
         .rstn   (rstn),
         .i_l    (w_l[g-1]),
         .i_r    (w_r[g-1]),
         .i_c    (w_c[g-1]),
         .i_d    (w_d[g-1]),
         .i_mode (w_m[g-1]),
         .i_valid(w_v[g-1]),
         .o_l    (w_l[g]),
         .o_r    (w_r[g]),
         .o_c    (w_c[g]),
         .o_d    (w_d[g]),
         .o_mode (w_m[g]),
         .o_valid(w_v[g])
      );
   end

   // Final swap R16||L16 then inverse initial permutation.
   assign w_fp      = fp_perm({w_r[16], w_l[16]});
   assign valid_out = w_v[16];

`ifdef DES_OUTPUT_GATE_EN
   assign cipher_text = valid_out ? w_fp : 64'h0;
`else
   assign cipher_text = w_fp;
`endif

endmodule

// File: tb/tb_des_top.sv
// Directed bench for des_top: a queue holds the expected result of every
// driven cycle and is popped 16 cycles later when the DUT presents it.
module tb_des_top;

   localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
   localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
   localparam logic [63:0] C1 = 64'h85E813540F0AB405;
   localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
   localparam logic [63:0] P2 = 64'h8787878787878787;
   localparam logic [63:0] C2 = 64'h0000000000000000;

   logic        clk = 1'b0;
   logic        rstn;
   logic [63:0] cipher_key;
   logic [63:0] plain_text;
   logic        encrypt_decrypt;
   logic        valid_in;
   logic [63:0] cipher_text;
   logic        valid_out;

   typedef struct packed {
      logic        v;
      logic [63:0] ct;
   } exp_t;

   exp_t q[$];
   int   errs   = 0;
   int   checks = 0;

   des_top dut (
      .clk            (clk),
      .rstn           (rstn),
      .cipher_key     (cipher_key),
      .plain_text     (plain_text),
      .encrypt_decrypt(encrypt_decrypt),
      .valid_in       (valid_in),
      .cipher_text    (cipher_text),
      .valid_out      (valid_out)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: compare the DUT against the oldest queued entry, then drive.
   task automatic step(input logic v, input logic md, input logic [63:0] k,
                       input logic [63:0] pt, input logic [63:0] ex);
      exp_t e;
      @(negedge clk);
      if (q.size() == 16) begin
         e = q.pop_front();
         chk1("valid_out", valid_out, e.v);
         if (e.v) chk64("cipher_text", cipher_text, e.ct);
`ifdef DES_OUTPUT_GATE_EN
         else chk64("gated_bubble", cipher_text, 64'h0);
`endif
      end else begin
         chk1("valid_out_empty", valid_out, 1'b0);
      end
      valid_in        = v;
      encrypt_decrypt = md;
      cipher_key      = k;
      plain_text      = pt;
      q.push_back({v, ex});
   endtask

   task automatic bubbles(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'bx, 'x, 'x, 64'h0);
   endtask

   initial begin
      rstn            = 1'b0;
      valid_in        = 1'b0;
      encrypt_decrypt = 1'b0;
      cipher_key      = '0;
      plain_text      = '0;
      #12;
      chk1("reset_valid_out", valid_out, 1'b0);
      chk64("reset_cipher_text", cipher_text, 64'h0);
      @(negedge clk);
      rstn = 1'b1;

      step(1'b1, 1'b0, K1, P1, C1);
      bubbles(3);
      step(1'b1, 1'b1, K1, C1, P1);
      bubbles(3);
      step(1'b1, 1'b0, K2, P2, C2);
      step(1'b1, 1'b1, K2, C2, P2);
      bubbles(2);

      step(1'b1, 1'b0, K1, P1, C1);
      step(1'b1, 1'b1, K2, C2, P2);
      step(1'b1, 1'b0, K2, P2, C2);
      step(1'b1, 1'b1, K1, C1, P1);

      step(1'b1, 1'b0, K1, P1, C1);
      bubbles(1);
      step(1'b1, 1'b1, K2, C2, P2);
      bubbles(17);

      step(1'b1, 1'b0, K1, P1, C1);
      bubbles(7);
      #2;
      rstn = 1'b0;
      #1;
      chk1("async_reset_valid_out", valid_out, 1'b0);
      chk64("async_reset_cipher_text", cipher_text, 64'h0);
      valid_in = 1'b0;
      @(negedge clk);
      chk1("in_reset_valid_out", valid_out, 1'b0);
      rstn = 1'b1;
      q.delete();
      bubbles(20);

      step(1'b1, 1'b1, K1, C1, P1);
      bubbles(17);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
